// File: rtl/kulisch_csa_acc.sv
// Exact dot-product accumulator fed by carry-save Booth products.
// Resolves each product, aligns it and folds it into a wide register.
module kulisch_csa_acc #(
    parameter int PW    = 22,
    parameter int ACC_W = 64,
    parameter int SH_W  = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    in_sum,
    input  logic [PW-1:0]    in_carry,
    input  logic [SH_W-1:0]  in_shift,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    localparam logic [1:0] ACC   = 2'd0;
    localparam logic [1:0] FLUSH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [SH_W-1:0] MAX_SH = SH_W'(ACC_W - PW);

    logic [1:0]       state;
    logic             s1_valid;
    logic [PW-1:0]    s1_p;
    logic [SH_W-1:0]  s1_shift;
    logic [ACC_W-1:0] acc;
    logic             ovf;

    logic             accept;
    logic             hand;
    logic [PW-1:0]    p;
    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] sum;
    logic             drop;
    logic             add_ovf;

    assign in_ready  = RST && (state == ACC);
    assign out_valid = RST && (state == HOLD);
    assign out_acc   = acc;
    assign out_ovf   = ovf;

    assign accept = in_valid && in_ready;
    assign hand   = (state == HOLD) && out_ready;

    // Carry bit i weighs 2^(i+1), so the carry vector enters shifted by one.
    assign p = in_sum + {in_carry[PW-2:0], 1'b0};

    assign term    = {{(ACC_W-PW){s1_p[PW-1]}}, s1_p} << s1_shift;
    assign sum     = acc + term;
    assign drop    = s1_shift > MAX_SH;
    assign add_ovf = (acc[ACC_W-1] == term[ACC_W-1])
                   && (sum[ACC_W-1] != acc[ACC_W-1]);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= ACC;
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_shift <= '0;
            acc      <= '0;
            ovf      <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_p     <= p;
                s1_shift <= in_shift;
            end

            case (state)
                ACC:     if (accept && in_last) state <= FLUSH;
                FLUSH:   state <= HOLD;
                HOLD:    if (out_ready) state <= ACC;
                default: state <= ACC;
            endcase

            if (hand) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (s1_valid) begin
                if (drop) begin
                    ovf <= 1'b1;
                end else begin
                    acc <= sum;
                    if (add_ovf) ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_kulisch_csa_acc.sv
// Bench for kulisch_csa_acc: directed frames plus random frames
// checked against an exact-integer accumulation model.
module tb_kulisch_csa_acc;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [21:0] in_sum;
    logic [21:0] in_carry;
    logic [5:0]  in_shift;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_acc;
    logic        out_ovf;

    int compared   = 0;
    int mismatched = 0;

    longint m_acc;
    bit     m_ovf;

    kulisch_csa_acc dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_carry(in_carry),
        .in_shift(in_shift), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_ovf(out_ovf)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] o,
                       input logic [63:0] e);
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Exact arithmetic: value of the term, then wrap to 64 bits.
    task automatic model_add(input logic [21:0] s, input logic [21:0] c,
                             input logic [5:0] sh);
        longint pv;
        logic signed [127:0] w;
        logic signed [127:0] hi;
        pv = (longint'(s) + 2 * longint'(c)) % (longint'(1) << 22);
        if (pv >= (longint'(1) << 21)) pv -= (longint'(1) << 22);
        if (sh > 42) begin
            m_ovf = 1'b1;
        end else begin
            hi = 128'sh7FFF_FFFF_FFFF_FFFF;
            w  = 128'(m_acc) + 128'(pv) * (128'sd1 <<< sh);
            if (w > hi || w < -hi - 1) m_ovf = 1'b1;
            m_acc = longint'(w[63:0]);
        end
    endtask

    task automatic send(input logic [21:0] s, input logic [21:0] c,
                        input logic [5:0] sh, input bit l);
        int n;
        in_valid = 1'b1;
        in_sum   = s;
        in_carry = c;
        in_shift = sh;
        in_last  = l;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_add(s, c, sh);
    endtask

    // Called one cycle after the last beat was accepted.
    task automatic expect_result(input string tag);
        chk({tag, "_c1_valid"}, {63'd0, out_valid}, 64'd0);
        step();
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_acc"}, out_acc, m_acc);
        chk({tag, "_ovf"}, {63'd0, out_ovf}, {63'd0, m_ovf});
    endtask

    task automatic take(input string tag, input int stall);
        logic [63:0] a;
        logic        v;
        a = out_acc;
        v = out_ovf;
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            step();
            chk({tag, "_hold_acc"}, out_acc, a);
            chk({tag, "_hold_ovf"}, {63'd0, out_ovf}, {63'd0, v});
            chk({tag, "_hold_rdy"}, {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_post_rdy"}, {63'd0, in_ready}, 64'd1);
        chk({tag, "_post_acc"}, out_acc, 64'd0);
        chk({tag, "_post_ovf"}, {63'd0, out_ovf}, 64'd0);
        m_acc = 0;
        m_ovf = 1'b0;
    endtask

    initial begin
        int nb;
        logic [5:0] sh;
        RST = 1'b0; in_valid = 1'b0; in_sum = '0; in_carry = '0;
        in_shift = '0; in_last = 1'b0; out_ready = 1'b0;
        m_acc = 0; m_ovf = 1'b0;
        step();
        chk("rst_ready", {63'd0, in_ready}, 64'd0);
        step();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_acc", out_acc, 64'd0);
        RST = 1'b1;
        #1;
        chk("rst_rel_ready", {63'd0, in_ready}, 64'd1);

        send(22'h000005, 22'h000001, 6'd0, 1'b1);
        expect_result("single");
        chk("single_lit", out_acc, 64'd7);
        take("single", 0);

        send(22'h3FFFFF, 22'h0, 6'd4, 1'b0);
        send(22'h000003, 22'h0, 6'd0, 1'b1);
        expect_result("signed");
        chk("signed_lit", out_acc, 64'hFFFF_FFFF_FFFF_FFF3);
        take("signed", 1);

        send(22'h000001, 22'h0, 6'd42, 1'b0);
        send(22'h000005, 22'h0, 6'd43, 1'b1);
        expect_result("bounds");
        chk("bounds_lit", out_acc, 64'h0000_0400_0000_0000);
        chk("bounds_ovf_lit", {63'd0, out_ovf}, 64'd1);
        take("bounds", 0);

        send(22'h100000, 22'h0, 6'd42, 1'b0);
        send(22'h100000, 22'h0, 6'd42, 1'b1);
        expect_result("ovf");
        chk("ovf_lit", out_acc, 64'h8000_0000_0000_0000);
        chk("ovf_flag_lit", {63'd0, out_ovf}, 64'd1);

        // Pending beat while HOLD is stalled must wait for the handshake.
        in_valid = 1'b1; in_sum = 22'd2; in_carry = '0;
        in_shift = '0; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_acc", out_acc, 64'h8000_0000_0000_0000);
            chk("bp_ovf", {63'd0, out_ovf}, 64'd1);
            chk("bp_rdy", {63'd0, in_ready}, 64'd0);
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_h1_rdy", {63'd0, in_ready}, 64'd1);
        chk("bp_h1_valid", {63'd0, out_valid}, 64'd0);
        m_acc = 0; m_ovf = 1'b0;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        model_add(22'd2, 22'd0, 6'd0);
        expect_result("bp_next");
        chk("bp_next_lit", out_acc, 64'd2);
        take("bp_next", 0);

        send(22'h000009, 22'h000002, 6'd3, 1'b1);
        expect_result("rst_hold");
        RST = 1'b0;
        step();
        chk("rsth_valid", {63'd0, out_valid}, 64'd0);
        chk("rsth_rdy", {63'd0, in_ready}, 64'd0);
        step();
        chk("rsth_acc", out_acc, 64'd0);
        chk("rsth_ovf", {63'd0, out_ovf}, 64'd0);
        RST = 1'b1;
        #1;
        chk("rsth_rel_rdy", {63'd0, in_ready}, 64'd1);
        m_acc = 0; m_ovf = 1'b0;

        for (int f = 0; f < 12; f++) begin
            nb = int'($urandom_range(1, 6));
            for (int b = 0; b < nb; b++) begin
                sh = ($urandom % 8 == 0) ? 6'($urandom_range(43, 63))
                                         : 6'($urandom_range(0, 42));
                out_ready = (b < nb - 1) ? 1'($urandom) : 1'b0;
                send(22'($urandom), 22'($urandom), sh, b == nb - 1);
            end
            expect_result("rand");
            take("rand", int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/kulisch_csa_acc.md
KULISCH_CSA_ACC -- requirements
Module: kulisch_csa_acc

Interface
REQ-001 The block SHALL have parameter PW, default 22, giving the carry-save product width in bits.
REQ-002 The block SHALL have parameter ACC_W, default 64, giving the accumulator width in bits.
REQ-003 The block SHALL have parameter SH_W, default 6, giving the alignment-shift field width in bits.
REQ-004 CLK  input  1  sole clock; all state changes on rising edge.
REQ-005 RST  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  term beat present.
REQ-007 in_ready  output  1  block accepts a term beat this cycle.
REQ-008 in_sum  input  PW  sum vector of a Booth multiplier product.
REQ-009 in_carry  input  PW  carry vector of the same product.
REQ-010 in_shift  input  SH_W  left alignment shift of the term, in bits.
REQ-011 in_last  input  1  marks the final term of a dot product.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_acc  output  ACC_W  signed two's-complement accumulated result.
REQ-015 out_ovf  output  1  sticky overflow/drop flag for the current result.

Function
REQ-016 An input beat SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-017 Stage 1 SHALL resolve each accepted beat as p = (in_sum + (in_carry << 1)) mod 2^PW, because carry bit i carries weight 2^(i+1), and register p with its shift and last flag.
REQ-018 Stage 2 SHALL sign-extend p from PW to ACC_W bits, shift it left by in_shift, and add the result to the accumulator register.
REQ-019 A term with in_shift > ACC_W-PW (42 by default) SHALL NOT be added to the accumulator, and SHALL set out_ovf.
REQ-020 A signed ACC_W-bit overflow on any accumulator add SHALL set out_ovf; the accumulator SHALL keep the wrapped sum.
REQ-021 out_ovf SHALL stay set until the result handshake completes or reset is applied.
REQ-022 The FSM SHALL have three states: ACC (in_ready=1), FLUSH (in_ready=0), and HOLD (in_ready=0, out_valid=1).
REQ-023 Acceptance of a beat with in_last=1 SHALL move the FSM from ACC to FLUSH.
REQ-024 The FSM SHALL move from FLUSH to HOLD unconditionally after one cycle.
REQ-025 The FSM SHALL move from HOLD to ACC on the cycle where out_ready=1.
REQ-026 Latency: if the in_last beat is accepted in cycle c, out_valid SHALL be 1 from cycle c+2, with out_acc containing every term of the frame.
REQ-027 Back-to-back beats SHALL be accepted every cycle while in ACC, with no bubbles.
REQ-028 out_acc and out_ovf SHALL be held stable while out_valid=1 and out_ready=0.
REQ-029 On the out handshake cycle h, the accumulator and out_ovf SHALL clear to 0 at the end of h.
REQ-030 In cycle h+1, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-031 out_ready asserted outside HOLD SHALL be ignored.
REQ-032 in_valid asserted while in_ready=0 SHALL be ignored; the beat is not consumed.
REQ-033 A frame of one beat (in_last on the first term) SHALL be legal and SHALL follow the same latency.

Reset
REQ-034 While RST=0 at a rising edge, the block SHALL clear the FSM to ACC, clear the stage-1 valid, set the accumulator to 0, and drive out_valid=0, out_acc=0, out_ovf=0.
REQ-035 in_ready SHALL be 0 while RST=0 and SHALL be 1 in the first cycle after RST=1.
REQ-036 Reset asserted in any state, including FLUSH or HOLD, SHALL discard the in-flight term and any pending result.

Verification
REQ-037 Reset: RST=0 for 2 cycles during HOLD -> out_valid=0, out_acc=0, out_ovf=0; in_ready=1 in the first cycle after release.
REQ-038 Single term: sum=22'h000005, carry=22'h000001, shift=0, last=1 accepted in cycle c -> out_acc=7 and out_valid=1 in cycle c+2, out_ovf=0.
REQ-039 Signed sum: beat {sum=22'h3FFFFF, carry=0, shift=4}, then beat {sum=3, carry=0, shift=0, last=1} -> out_acc=64'hFFFF_FFFF_FFFF_FFF3.
REQ-040 Shift bounds: {p=1, shift=42} then {p=5, shift=43, last} -> out_acc=64'h0000_0400_0000_0000, out_ovf=1.
REQ-041 Overflow: two beats of sum=22'h100000, shift=42 -> out_acc=64'h8000_0000_0000_0000, out_ovf=1.
REQ-042 Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_acc/out_ovf stable and in_ready=0 throughout; after the handshake, next frame {p=2, shift=0, last} -> out_acc=2.
